seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for up to 8 common-anode 7-segment digits. Scans one digit per

---
 rtl/seg_scan_driver_pkg.sv | 19 +
 rtl/seg_scan_driver_decoder.sv | 11 +
 rtl/seg_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and the hex-to-7-segment table for the scanned display driver.
package seg_scan_driver_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, 1 = segment lit

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  localparam seg7_t HEX7SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg_scan_driver_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex7seg_decoder
  import seg_scan_driver_pkg::*;
(
  input  nibble_t i_nib,
  output seg7_t   o_seg
);

  assign o_seg = HEX7SEG[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with double-buffered data, anti-ghost
// blanking, PWM brightness, per-digit blanking and leading-zero suppression.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int N_DIG       = 8,
  parameter int DIV         = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] value_i,
  input  logic [N_DIG-1:0]   dp_i,
  input  logic               load_i,
  input  logic [N_DIG-1:0]   blank_i,
  input  logic               lz_en_i,
  input  logic [3:0]         bright_i,
  output logic               pending_o,
  output logic               frame_o,
  output logic [N_DIG-1:0]   AN,
  output logic [6:0]         SEG,
  output logic               DP
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic AN_INV  = (AN_ACT_LOW != 0);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);

  localparam logic [N_DIG-1:0] AN_OFF  = {N_DIG{AN_INV}};
  localparam seg7_t            SEG_OFF = {7{SEG_INV}};

  if (N_DIG < 1 || N_DIG > 8 || DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= DIV) begin : g_param_err
    $error("seg_scan_driver: illegal parameters N_DIG=%0d DIV=%0d BLANK_CYC=%0d",
           N_DIG, DIV, BLANK_CYC);
  end

  logic [CW-1:0]      r_ctr;
  logic [IW-1:0]      r_idx;
  logic [3:0]         r_pwm;
  logic [4*N_DIG-1:0] r_shd_val;
  logic [N_DIG-1:0]   r_shd_dp;
  logic [4*N_DIG-1:0] r_act_val;
  logic [N_DIG-1:0]   r_act_dp;
  logic               r_pending;
  logic [N_DIG-1:0]   r_an;
  seg7_t              r_seg;
  logic               r_dp;

  logic               w_ctr_last;
  logic               w_idx_last;
  logic               w_frame;
  phase_e             w_phase;
  nibble_t            w_nib;
  seg7_t              w_seg;
  logic               w_dp_sel;
  logic               w_blank_sel;
  logic               w_zero_sel;
  logic [N_DIG-1:0]   w_zero_hi;
  logic               w_run;
  logic               w_lit;
  logic [N_DIG-1:0]   w_an_hot;

  assign w_ctr_last = (r_ctr == CW'(DIV - 1));
  assign w_idx_last = (r_idx == IW'(N_DIG - 1));
  assign w_frame    = w_ctr_last && w_idx_last;
  assign w_phase    = (r_ctr < CW'(BLANK_CYC)) ? PH_BLANK : PH_ON;

  // w_zero_hi[k]: active nibbles k..N_DIG-1 are all zero (built from the top down).
  always_comb begin
    w_zero_hi = '0;
    w_run     = 1'b1;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      w_run = w_run && (r_act_val[4*(N_DIG-1-i) +: 4] == 4'h0);
      w_zero_hi[N_DIG-1-i] = w_run;
    end
  end

  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_zero_sel  = 1'b0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib       = r_act_val[4*k +: 4];
        w_dp_sel    = r_act_dp[k];
        w_blank_sel = blank_i[k];
        w_zero_sel  = (k != 0) && w_zero_hi[k];
      end
    end
  end

  assign w_lit = (w_phase == PH_ON) && (r_pwm <= bright_i) && !w_blank_sel
              && !(lz_en_i && w_zero_sel);

  always_comb begin
    w_an_hot = '0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (r_idx == IW'(k)) w_an_hot[k] = w_lit;
    end
  end

  hex7seg_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr <= '0;
      r_idx <= '0;
      r_pwm <= '0;
    end else begin
      if (w_ctr_last) begin
        r_ctr <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
        r_ctr <= r_ctr + 1'b1;
      end
      r_pwm <= (r_ctr == CW'(BLANK_CYC)) ? '0 : r_pwm + 1'b1;
    end
  end

  // Active copy only changes on the frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shd_val <= '0;
      r_shd_dp  <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load_i) begin
        r_shd_val <= value_i;
        r_shd_dp  <= dp_i;
      end
      if (w_frame && r_pending) begin
        r_act_val <= r_shd_val;
        r_act_dp  <= r_shd_dp;
      end
      if (load_i) begin
        r_pending <= 1'b1;
      end else if (w_frame) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= SEG_INV;
    end else begin
      r_an  <= w_an_hot ^ AN_OFF;
      r_seg <= w_lit ? (w_seg ^ SEG_OFF) : SEG_OFF;
      r_dp  <= w_lit ? (w_dp_sel ^ SEG_INV) : SEG_INV;
    end
  end

  assign pending_o = r_pending;
  assign frame_o   = w_frame;
  assign AN        = r_an;
  assign SEG       = r_seg;
  assign DP        = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV=20, BLANK_CYC=4, N_DIG=4, active-low outputs.
module tb_seg_scan_driver;

  localparam int N_DIG     = 4;
  localparam int DIV       = 20;
  localparam int BLANK_CYC = 4;
  localparam int FRAME     = N_DIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  blank_i = '0;
  logic        lz_en_i = 1'b0;
  logic [3:0]  bright_i = 4'd15;
  logic        pending_o;
  logic        frame_o;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;     // edges since reset release; outputs reflect scan position cyc-1

  logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};   // digits 4,3,2,1 inverted

  always #5 clk = ~clk;

  seg_scan_driver #(
    .N_DIG       (N_DIG),
    .DIV         (DIV),
    .BLANK_CYC   (BLANK_CYC),
    .AN_ACT_LOW  (1),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_i   (value_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .blank_i   (blank_i),
    .lz_en_i   (lz_en_i),
    .bright_i  (bright_i),
    .pending_o (pending_o),
    .frame_o   (frame_o),
    .AN        (AN),
    .SEG       (SEG),
    .DP        (DP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the outputs show digit slot d at counter value c.
  task automatic wait_out(input int d, input int c);
    int n = 0;
    int tgt = d * DIV + c;
    do begin
      tick();
      n++;
    end while (((cyc - 1) % FRAME) != tgt && n < 2 * FRAME);
    if (((cyc - 1) % FRAME) != tgt) check("wait_out_tmo", (cyc - 1) % FRAME, tgt);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_o && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (!frame_o) check("frame_tmo", frame_o, 1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value_i = v;
    dp_i    = d;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  // Load and let the next frame boundary move the data into the active register.
  task automatic commit(input logic [15:0] v, input logic [3:0] d);
    load_val(v, d);
    wait_frame();
    tick();
  endtask

  task automatic count_lit(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (AN != 4'hF) cnt++;
    end
  endtask

  task automatic check_slot(input string tag, input int d, input logic [3:0] an,
                            input logic [6:0] seg);
    wait_out(d, 10);
    check($sformatf("%s_an%0d", tag, d), AN, an);
    check($sformatf("%s_seg%0d", tag, d), SEG, seg);
  endtask

  initial begin
    int cnt;

    tick();
    tick();
    check("rst_an", AN, 4'hF);
    check("rst_seg", SEG, 7'h7F);
    check("rst_dp", DP, 1'b1);
    check("rst_pend", pending_o, 1'b0);
    check("rst_frame", frame_o, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // 1: basic scan of 0x1234
    load_val(16'h1234, 4'h0);
    check("t1_pend", pending_o, 1'b1);
    check_slot("t1_old", 0, 4'hE, 7'h40);
    wait_frame();
    check("t1_frame_cyc", cyc, FRAME - 1);
    tick();
    check("t1_frame_pulse", frame_o, 1'b0);
    check("t1_pend_clr", pending_o, 1'b0);
    for (int d = 0; d < 4; d++) begin
      wait_out(d, 3);
      check($sformatf("t1_blank%0d", d), AN, 4'hF);
      wait_out(d, 4);
      check($sformatf("t1_on%0d", d), AN, an_exp[d]);
      wait_out(d, 10);
      check($sformatf("t1_seg%0d", d), SEG, seg1234[d]);
      check($sformatf("t1_dp%0d", d), DP, 1'b1);
    end

    // 2: brightness extremes
    bright_i = 4'd0;
    wait_out(0, 0);
    count_lit(FRAME, cnt);
    check("t2_bright0", cnt, 4);
    bright_i = 4'd15;
    wait_out(0, 0);
    count_lit(FRAME, cnt);
    check("t2_bright15", cnt, 64);

    // 3: leading-zero suppression
    lz_en_i = 1'b1;
    commit(16'h0050, 4'h0);
    check_slot("t3", 0, 4'hE, 7'h40);
    check_slot("t3", 1, 4'hD, 7'h12);
    check_slot("t3", 2, 4'hF, 7'h7F);
    check_slot("t3", 3, 4'hF, 7'h7F);
    wait_out(0, 0);
    count_lit(FRAME, cnt);
    check("t3_cnt50", cnt, 32);
    commit(16'h0000, 4'h0);
    wait_out(0, 0);
    count_lit(FRAME, cnt);
    check("t3_cnt00", cnt, 16);
    check_slot("t3z", 0, 4'hE, 7'h40);
    lz_en_i = 1'b0;

    // 4: double buffering
    wait_out(1, 10);
    load_val(16'h9ABC, 4'h0);
    check("t4_pend", pending_o, 1'b1);
    check_slot("t4_old", 3, 4'h7, 7'h40);
    wait_frame();
    check("t4_pend_hold", pending_o, 1'b1);
    tick();
    check("t4_pend_clr", pending_o, 1'b0);
    check_slot("t4_new", 0, 4'hE, 7'h46);
    check_slot("t4_new", 3, 4'h7, 7'h10);

    wait_out(1, 10);
    load_val(16'h5555, 4'h0);
    wait_frame();
    value_i = 16'h2222;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
    check("t4_bnd_pend", pending_o, 1'b1);
    check_slot("t4_bnd1", 0, 4'hE, 7'h12);
    wait_frame();
    tick();
    check("t4_bnd_clr", pending_o, 1'b0);
    check_slot("t4_bnd2", 0, 4'hE, 7'h24);

    wait_out(1, 10);
    load_val(16'h3333, 4'h0);
    load_val(16'h4444, 4'h0);
    wait_frame();
    tick();
    check_slot("t4_last", 0, 4'hE, 7'h19);

    // 5: per-digit blanking and decimal point
    blank_i = 4'b0100;
    wait_out(0, 0);
    count_lit(FRAME, cnt);
    check("t5_blank_cnt", cnt, 48);
    check_slot("t5_blank", 2, 4'hF, 7'h7F);
    blank_i = 4'b0000;
    commit(16'h1234, 4'b0001);
    wait_out(0, 10);
    check("t5_dp0", DP, 1'b0);
    wait_out(1, 10);
    check("t5_dp1", DP, 1'b1);
    wait_out(0, 2);
    check("t5_dp0_blank", DP, 1'b1);

    // 6: reset mid-slot discards pending data
    load_val(16'h9999, 4'h0);
    check("t6_pend", pending_o, 1'b1);
    wait_out(1, 7);
    rst = 1'b1;
    tick();
    check("t6_an", AN, 4'hF);
    check("t6_seg", SEG, 7'h7F);
    check("t6_pend", pending_o, 1'b0);
    check("t6_frame", frame_o, 1'b0);
    rst = 1'b0;
    cyc = 0;
    wait_out(0, 4);
    check("t6_idx0", AN, 4'hE);
    check_slot("t6_zero", 0, 4'hE, 7'h40);
    check("t6_dp", DP, 1'b1);
    wait_frame();
    check("t6_frame_cyc", cyc, FRAME - 1);
    tick();
    check("t6_no_pend", pending_o, 1'b0);
    check_slot("t6_after", 0, 4'hE, 7'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
